// File: rtl/mem_wb_pipe_reg_pkg.sv
// Shared pipeline definitions for the MEM/WB boundary: datapath widths and
// write-back control encoding, also used by EX/MEM and the register file.
package mem_wb_pipe_reg_pkg;
    localparam int DATA_W      = 32;
    localparam int REG_ADDR_W  = 5;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    typedef logic [1:0] wb_ctrl_t;

    localparam wb_ctrl_t WB_BUBBLE = 2'b00;
endpackage

// File: rtl/mem_wb_pipe_reg_wb_select.sv
// Write-back data mux and register-file write enable; writes to $zero are
// suppressed here so no downstream stage has to special-case register 0.
module wb_select
    import mem_wb_pipe_reg_pkg::*;
#(
    parameter int DW = mem_wb_pipe_reg_pkg::DATA_W,
    parameter int AW = mem_wb_pipe_reg_pkg::REG_ADDR_W
) (
    input  wb_ctrl_t        ctrl_i,
    input  logic [DW-1:0]   rd_data_i,
    input  logic [DW-1:0]   alu_res_i,
    input  logic [AW-1:0]   dst_i,
    output logic            reg_write_o,
    output logic [DW-1:0]   write_data_o
);
    always_comb begin
        reg_write_o  = ctrl_i[WB_REGWRITE] && (dst_i != '0);
        write_data_o = ctrl_i[WB_MEMTOREG] ? rd_data_i : alu_res_i;
    end
endmodule

// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register: captures MEM results on a data-cache hit and
// turns a miss into a write-back bubble while holding the datapath fields.
module mem_wb_pipe_reg #(
    parameter int DATA_W     = mem_wb_pipe_reg_pkg::DATA_W,
    parameter int REG_ADDR_W = mem_wb_pipe_reg_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_hit,
    input  logic [1:0]            control_wb_in,
    input  logic [DATA_W-1:0]     Read_data_in,
    input  logic [DATA_W-1:0]     ALU_result_in,
    input  logic [REG_ADDR_W-1:0] Write_reg_in,
    output logic [1:0]            control_wb_out,
    output logic [DATA_W-1:0]     Read_data_out,
    output logic [DATA_W-1:0]     ALU_result_out,
    output logic [REG_ADDR_W-1:0] Write_reg_out,
    output logic                  reg_write,
    output logic [DATA_W-1:0]     write_data
);
    import mem_wb_pipe_reg_pkg::*;

    wb_ctrl_t              ctrl_q,  ctrl_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic [DATA_W-1:0]     alu_q,   alu_d;
    logic [REG_ADDR_W-1:0] wreg_q,  wreg_d;

    // Only the control word needs clearing on a miss; the data fields are
    // held so their values stay stable while the bubble is in WB.
    always_comb begin
        ctrl_d  = WB_BUBBLE;
        rdata_d = rdata_q;
        alu_d   = alu_q;
        wreg_d  = wreg_q;
        if (data_hit) begin
            ctrl_d  = control_wb_in;
            rdata_d = Read_data_in;
            alu_d   = ALU_result_in;
            wreg_d  = Write_reg_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q  <= WB_BUBBLE;
            rdata_q <= '0;
            alu_q   <= '0;
            wreg_q  <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            rdata_q <= rdata_d;
            alu_q   <= alu_d;
            wreg_q  <= wreg_d;
        end
    end

    assign control_wb_out = ctrl_q;
    assign Read_data_out  = rdata_q;
    assign ALU_result_out = alu_q;
    assign Write_reg_out  = wreg_q;

    wb_select #(
        .DW (DATA_W),
        .AW (REG_ADDR_W)
    ) u_wb_select (
        .ctrl_i       (ctrl_q),
        .rd_data_i    (rdata_q),
        .alu_res_i    (alu_q),
        .dst_i        (wreg_q),
        .reg_write_o  (reg_write),
        .write_data_o (write_data)
    );
endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Directed bench for mem_wb_pipe_reg: reset, a table of per-edge vectors
// (capture, write-back select, $zero, miss bubbles) and a mid-cycle reset.
module tb_mem_wb_pipe_reg;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        data_hit;
    logic [1:0]  control_wb_in;
    logic [31:0] Read_data_in;
    logic [31:0] ALU_result_in;
    logic [4:0]  Write_reg_in;
    logic [1:0]  control_wb_out;
    logic [31:0] Read_data_out;
    logic [31:0] ALU_result_out;
    logic [4:0]  Write_reg_out;
    logic        reg_write;
    logic [31:0] write_data;

    int n_pass = 0;
    int n_total = 0;

    always #50 clk = ~clk;

    mem_wb_pipe_reg dut (
        .clk            (clk),
        .rst            (rst),
        .data_hit       (data_hit),
        .control_wb_in  (control_wb_in),
        .Read_data_in   (Read_data_in),
        .ALU_result_in  (ALU_result_in),
        .Write_reg_in   (Write_reg_in),
        .control_wb_out (control_wb_out),
        .Read_data_out  (Read_data_out),
        .ALU_result_out (ALU_result_out),
        .Write_reg_out  (Write_reg_out),
        .reg_write      (reg_write),
        .write_data     (write_data)
    );

    typedef struct {
        logic        hit;
        logic [1:0]  ctrl;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic [1:0]  e_ctrl;
        logic [31:0] e_rd;
        logic [31:0] e_alu;
        logic [4:0]  e_wr;
        logic        e_rw;
        logic [31:0] e_wd;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic chk_all(input string tag, input logic [1:0] c, input logic [31:0] rd,
                           input logic [31:0] alu, input logic [4:0] wr,
                           input logic rw, input logic [31:0] wd);
        chk({tag, ".ctrl"},  {30'd0, control_wb_out}, {30'd0, c});
        chk({tag, ".rd"},    Read_data_out, rd);
        chk({tag, ".alu"},   ALU_result_out, alu);
        chk({tag, ".wr"},    {27'd0, Write_reg_out}, {27'd0, wr});
        chk({tag, ".rw"},    {31'd0, reg_write}, {31'd0, rw});
        chk({tag, ".wd"},    write_data, wd);
    endtask

    task automatic drive(input logic h, input logic [1:0] c, input logic [31:0] rd,
                         input logic [31:0] alu, input logic [4:0] wr);
        data_hit = h; control_wb_in = c; Read_data_in = rd;
        ALU_result_in = alu; Write_reg_in = wr;
    endtask

    initial begin
        //          hit ctrl  rd            alu       wr     e_ctrl e_rd          e_alu     e_wr   rw    e_wd
        vecs[0] = '{1'b1, 2'b01, 32'd2,        32'h10,   5'd5,  2'b01, 32'd2,        32'h10,   5'd5,  1'b0, 32'd2};
        vecs[1] = '{1'b1, 2'b11, 32'hDEADBEEF, 32'h20,   5'd8,  2'b11, 32'hDEADBEEF, 32'h20,   5'd8,  1'b1, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 2'b10, 32'h55,       32'h1234, 5'd3,  2'b10, 32'h55,       32'h1234, 5'd3,  1'b1, 32'h1234};
        vecs[3] = '{1'b1, 2'b10, 32'h55,       32'h1234, 5'd0,  2'b10, 32'h55,       32'h1234, 5'd0,  1'b0, 32'h1234};
        vecs[4] = '{1'b1, 2'b11, 32'd7,        32'h40,   5'd9,  2'b11, 32'd7,        32'h40,   5'd9,  1'b1, 32'd7};
        vecs[5] = '{1'b0, 2'b11, 32'd9,        32'h44,   5'd10, 2'b00, 32'd7,        32'h40,   5'd9,  1'b0, 32'h40};
        vecs[6] = '{1'b0, 2'b11, 32'd9,        32'h44,   5'd10, 2'b00, 32'd7,        32'h40,   5'd9,  1'b0, 32'h40};
        vecs[7] = '{1'b1, 2'b11, 32'd9,        32'h44,   5'd10, 2'b11, 32'd9,        32'h44,   5'd10, 1'b1, 32'd9};
        vecs[8] = '{1'b0, 2'b01, 32'hAA,       32'hBB,   5'd1,  2'b00, 32'd9,        32'h44,   5'd10, 1'b0, 32'h44};
        vecs[9] = '{1'b1, 2'b00, 32'd1,        32'd2,    5'd31, 2'b00, 32'd1,        32'd2,    5'd31, 1'b0, 32'd2};

        // Load something nonzero, then reset asynchronously with the clock running.
        drive(1'b1, 2'b11, 32'hCAFE0001, 32'hCAFE0002, 5'd17);
        @(posedge clk); #1;
        chk_all("preload", 2'b11, 32'hCAFE0001, 32'hCAFE0002, 5'd17, 1'b1, 32'hCAFE0001);
        #20 rst = 1'b1;
        #1 chk_all("rst_async", 2'b00, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
        repeat (2) @(posedge clk);
        #1 chk_all("rst_hold", 2'b00, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].hit, vecs[i].ctrl, vecs[i].rd, vecs[i].alu, vecs[i].wr);
            @(posedge clk); #1;
            chk_all($sformatf("vec%0d", i), vecs[i].e_ctrl, vecs[i].e_rd, vecs[i].e_alu,
                    vecs[i].e_wr, vecs[i].e_rw, vecs[i].e_wd);
        end

        // Mid-cycle reset pulse while holding valid data, then normal capture.
        drive(1'b1, 2'b11, 32'h77, 32'h66, 5'd4);
        @(posedge clk); #1;
        chk_all("pre_mid", 2'b11, 32'h77, 32'h66, 5'd4, 1'b1, 32'h77);
        #20 rst = 1'b1;
        #1 chk_all("mid_rst", 2'b00, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
        #10 rst = 1'b0;
        #1 chk_all("mid_rel", 2'b00, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
        drive(1'b1, 2'b10, 32'h88, 32'h99, 5'd6);
        @(posedge clk); #1;
        chk_all("post_mid", 2'b10, 32'h88, 32'h99, 5'd6, 1'b1, 32'h99);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
